// File: rtl/conv_pkg.sv
// Shared definitions for the 5x5 convolution window generator: kernel geometry,
// a default-width window type and the frame-tracking FSM states.
package conv_pkg;

    localparam int KERNEL_SIZE      = 5;
    localparam int LB_COUNT         = KERNEL_SIZE - 1;
    localparam int DEFAULT_BITWIDTH = 32;

    // [i][j]: i = row (0 = top/oldest), j = column (0 = leftmost)
    typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DEFAULT_BITWIDTH-1:0] window_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage: single port, registered read-before-write at a
// column address. The array itself is not reset so it can map onto RAM.
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_d;
    logic [WIDTH-1:0] rd_q;

    always_comb begin
        rd_d = rd_q;
        if (en) begin
            rd_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en && wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to 5x5 sliding window (unpadded windows only).
// Optional feature: `define CONV_WIN_STALL_CNT_EN adds the stall_cnt output.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    localparam int CW      = $clog2(IMG_W),
    localparam int RW      = $clog2(IMG_H)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITWIDTH-1:0]  in_pixel,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][BITWIDTH-1:0] map_block,
    output logic [RW-1:0]        win_row,
    output logic [CW-1:0]        win_col,
    output logic                 frame_done
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    rot_q, rot_d;
    logic [1:0]    sel_q, sel_d;
    logic [BITWIDTH-1:0] pix_q, pix_d;
    logic [KERNEL_SIZE-1:0][LB_COUNT-1:0][BITWIDTH-1:0] win_q, win_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;

    logic [BITWIDTH-1:0] lb_rd   [LB_COUNT];
    logic [BITWIDTH-1:0] col_now [KERNEL_SIZE];
    logic accept;
    logic win_hs;
    logic last_col;
    logic last_row;

    // Single output slot: a new pixel may enter whenever the slot empties this cycle.
    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign win_hs   = win_valid_q && win_ready;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    // Rows rotate through the buffers instead of being copied between them;
    // rot_q names the buffer holding the oldest row, written with the newest.
    for (genvar k = 0; k < LB_COUNT; k++) begin : g_lb
        conv_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (BITWIDTH)
        ) u_lb (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (accept),
            .wr_en   (rot_q == 2'(k)),
            .addr    (col_q),
            .wr_data (in_pixel),
            .rd_data (lb_rd[k])
        );
    end

    always_comb begin
        for (int i = 0; i < LB_COUNT; i++) begin
            col_now[i] = lb_rd[sel_q + 2'(i)];
        end
        col_now[KERNEL_SIZE-1] = pix_q;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < LB_COUNT; j++) begin
                map_block[i][j] = win_q[i][j];
            end
            map_block[i][KERNEL_SIZE-1] = col_now[i];
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        rot_d       = rot_q;
        sel_d       = sel_q;
        pix_d       = pix_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (win_hs) begin
            win_valid_d = 1'b0;
        end
        if (accept) begin
            sel_d = rot_q;
            pix_d = in_pixel;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                for (int j = 0; j < LB_COUNT - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][LB_COUNT-1] = col_now[i];
            end
            if (last_col) begin
                col_d = '0;
                rot_d = rot_q + 2'd1;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // Rows 0..3 and columns 0..3 only prime the window (stale or wrapped data).
            if (row_q >= RW'(4) && col_q >= CW'(4)) begin
                win_valid_d = 1'b1;
                win_row_d   = row_q - RW'(4);
                win_col_d   = col_q - CW'(4);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (accept && last_col && last_row) state_d = LAST;
            LAST: begin
                if (win_hs) begin
                    frame_done = 1'b1;
                    state_d    = accept ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            rot_q       <= '0;
            sel_q       <= '0;
            pix_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rot_q       <= rot_d;
            sel_q       <= sel_d;
            pix_q       <= pix_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (frame_done) begin
            stall_cnt_d = '0;
        end else if (win_valid_q && !win_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
